// File: rtl/urv_mem_arbiter.sv
// -----------------------------------------------------------------------------
// urv_mem_arbiter
//
// Shares one synchronous single-port SRAM between the uRV instruction-fetch
// port and the data-memory port. Up to two data requests are queued in a small
// FIFO. Queued data requests take priority over fetch, but after
// g_max_dm_burst consecutive data grants one cycle is forced to fetch so the
// core can never be starved of instructions.
//
// Ports
//   clk_i, rst_n_i      clock (rising edge), asynchronous active-low reset
//   im_addr_i           fetch byte address
//   im_data_o           fetched instruction word
//   im_valid_o          im_data_o belongs to the current im_addr_i
//   dm_addr_i           data byte address
//   dm_data_s_i         store data
//   dm_data_select_i    store byte enables
//   dm_load_i           one-cycle load strobe
//   dm_store_i          one-cycle store strobe (wins if both strobes are set)
//   dm_ready_o          a strobe presented this cycle is accepted
//   dm_data_l_o         load data
//   dm_load_done_o      one-cycle load completion pulse
//   dm_store_done_o     one-cycle store completion pulse
//   mem_en_o            SRAM access enable
//   mem_we_o            SRAM write enable
//   mem_be_o            SRAM byte enables
//   mem_addr_o          SRAM word address
//   mem_wdata_o         SRAM write data
//   mem_rdata_i         SRAM read data, valid the cycle after a read access
// -----------------------------------------------------------------------------
module urv_mem_arbiter #(
  parameter int g_addr_width   = 14,
  parameter int g_max_dm_burst = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [31:0]             im_addr_i,
  output logic [31:0]             im_data_o,
  output logic                    im_valid_o,
  input  logic [31:0]             dm_addr_i,
  input  logic [31:0]             dm_data_s_i,
  input  logic [3:0]              dm_data_select_i,
  input  logic                    dm_load_i,
  input  logic                    dm_store_i,
  output logic                    dm_ready_o,
  output logic [31:0]             dm_data_l_o,
  output logic                    dm_load_done_o,
  output logic                    dm_store_done_o,
  output logic                    mem_en_o,
  output logic                    mem_we_o,
  output logic [3:0]              mem_be_o,
  output logic [g_addr_width-1:0] mem_addr_o,
  output logic [31:0]             mem_wdata_o,
  input  logic [31:0]             mem_rdata_i
);

  // Type of the access made in the previous cycle; its result is completed
  // this cycle because the SRAM returns read data one cycle late.
  typedef enum logic [1:0] {
    ACC_NONE  = 2'd0,
    ACC_FETCH = 2'd1,
    ACC_LOAD  = 2'd2,
    ACC_STORE = 2'd3
  } acc_t;

  localparam logic [3:0] MAX_BURST = 4'(g_max_dm_burst);

  // Request FIFO storage (2 entries).
  logic                    fifo_store [2];
  logic [g_addr_width-1:0] fifo_addr  [2];
  logic [31:0]             fifo_data  [2];
  logic [3:0]              fifo_sel   [2];
  logic                    wr_ptr;
  logic                    rd_ptr;
  logic [1:0]              count;

  logic                    full;
  logic                    empty;
  logic                    req;
  logic                    push;
  logic                    dm_grant;

  logic                    head_store;
  logic [g_addr_width-1:0] head_addr;
  logic [31:0]             head_data;
  logic [3:0]              head_sel;

  logic [3:0]              burst_cnt;
  acc_t                    inflight_q;
  acc_t                    inflight_d;
  logic [g_addr_width-1:0] fetch_addr;
  logic [g_addr_width-1:0] fetch_addr_q;
  logic [31:0]             im_data_q;
  logic [31:0]             dm_data_q;

  // Only the word-address slice of the CPU addresses reaches the SRAM.
  logic                    unused_addr_bits;
  assign unused_addr_bits = ^{im_addr_i, dm_addr_i};

  // Handshake: dm_ready_o depends only on FIFO occupancy. A request is the OR
  // of dm_load_i/dm_store_i and is taken at the rising edge of any cycle in
  // which dm_ready_o is high; a request seen while dm_ready_o is low is lost
  // and never completes. The requester never has to hold a strobe.
  assign full       = (count == 2'd2);
  assign empty      = (count == 2'd0);
  assign dm_ready_o = !full;
  assign req        = dm_load_i | dm_store_i;
  assign push       = req && !full;

  assign head_store = fifo_store[rd_ptr];
  assign head_addr  = fifo_addr[rd_ptr];
  assign head_data  = fifo_data[rd_ptr];
  assign head_sel   = fifo_sel[rd_ptr];

  // Data wins unless the burst limit has been reached; every other cycle
  // (including an empty FIFO) is a fetch.
  assign dm_grant   = !empty && (burst_cnt < MAX_BURST);
  assign fetch_addr = im_addr_i[g_addr_width+1:2];

  // Request FIFO.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_store[i] <= 1'b0;
        fifo_addr[i]  <= '0;
        fifo_data[i]  <= '0;
        fifo_sel[i]   <= '0;
      end
    end else begin
      if (push) begin
        fifo_store[wr_ptr] <= dm_store_i;
        fifo_addr[wr_ptr]  <= dm_addr_i[g_addr_width+1:2];
        fifo_data[wr_ptr]  <= dm_data_s_i;
        fifo_sel[wr_ptr]   <= dm_data_select_i;
        wr_ptr             <= ~wr_ptr;
      end
      if (dm_grant) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, dm_grant})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Next in-flight access type.
  always_comb begin
    inflight_d = ACC_FETCH;
    if (dm_grant) begin
      inflight_d = head_store ? ACC_STORE : ACC_LOAD;
    end
  end

  // Arbitration state and held output data.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      burst_cnt    <= 4'd0;
      inflight_q   <= ACC_NONE;
      fetch_addr_q <= '0;
      im_data_q    <= '0;
      dm_data_q    <= '0;
    end else begin
      // Saturating run length of data grants; any fetch grant restarts it.
      if (dm_grant) begin
        burst_cnt <= (burst_cnt == 4'hF) ? burst_cnt : burst_cnt + 4'd1;
      end else begin
        burst_cnt <= 4'd0;
      end
      inflight_q <= inflight_d;
      if (!dm_grant) begin
        fetch_addr_q <= fetch_addr;
      end
      im_data_q <= im_data_o;
      dm_data_q <= dm_data_l_o;
    end
  end

  // SRAM side: combinational from grant, FIFO head and fetch address; held
  // idle while reset is asserted.
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (rst_n_i) begin
      mem_en_o = 1'b1;
      if (dm_grant) begin
        mem_we_o    = head_store;
        mem_be_o    = head_store ? head_sel : 4'hF;
        mem_addr_o  = head_addr;
        mem_wdata_o = head_data;
      end else begin
        mem_be_o   = 4'hF;
        mem_addr_o = fetch_addr;
      end
    end
  end

  // Completion of the access granted last cycle. Read data is passed straight
  // from the SRAM in its completion cycle and held afterwards. A fetch is only
  // reported valid if the core still wants the same word; otherwise the next
  // fetch grant simply reads the new address.
  assign dm_load_done_o  = (inflight_q == ACC_LOAD);
  assign dm_store_done_o = (inflight_q == ACC_STORE);
  assign im_valid_o      = (inflight_q == ACC_FETCH) && (fetch_addr == fetch_addr_q);
  assign im_data_o       = (inflight_q == ACC_FETCH) ? mem_rdata_i : im_data_q;
  assign dm_data_l_o     = (inflight_q == ACC_LOAD) ? mem_rdata_i : dm_data_q;

endmodule

// File: tb/tb_urv_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_urv_mem_arbiter
//
// Directed bench for urv_mem_arbiter with a behavioural single-port SRAM.
// Data requests push their hand-computed response into exp_q; a monitor pops
// and compares on every done pulse, and checks each valid fetch word. A
// per-cycle trace of the SRAM side is checked against hand-derived grant
// timing after each scenario.
// -----------------------------------------------------------------------------
module tb_urv_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] im_addr;
  logic [31:0] im_data_o;
  logic        im_valid_o;
  logic [31:0] dm_addr;
  logic [31:0] dm_data_s;
  logic [3:0]  dm_sel;
  logic        dm_load;
  logic        dm_store;
  logic        dm_ready_o;
  logic [31:0] dm_data_l_o;
  logic        dm_load_done_o;
  logic        dm_store_done_o;
  logic        mem_en_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [13:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata = 32'h13;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  urv_mem_arbiter #(
    .g_addr_width   (14),
    .g_max_dm_burst (3)
  ) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .im_addr_i        (im_addr),
    .im_data_o        (im_data_o),
    .im_valid_o       (im_valid_o),
    .dm_addr_i        (dm_addr),
    .dm_data_s_i      (dm_data_s),
    .dm_data_select_i (dm_sel),
    .dm_load_i        (dm_load),
    .dm_store_i       (dm_store),
    .dm_ready_o       (dm_ready_o),
    .dm_data_l_o      (dm_data_l_o),
    .dm_load_done_o   (dm_load_done_o),
    .dm_store_done_o  (dm_store_done_o),
    .mem_en_o         (mem_en_o),
    .mem_we_o         (mem_we_o),
    .mem_be_o         (mem_be_o),
    .mem_addr_o       (mem_addr_o),
    .mem_wdata_o      (mem_wdata_o),
    .mem_rdata_i      (mem_rdata)
  );

  // ---------------- SRAM model ----------------
  // Unwritten words read a fixed pattern: 0x40 -> 0x13, 0x41 -> 0x17,
  // otherwise 0xC0DE0000 | word_address.
  logic [31:0] mem_arr [0:16383];
  bit          written [0:16383];

  function automatic logic [31:0] base_word(input logic [13:0] a);
    if (a == 14'h40) return 32'h13;
    if (a == 14'h41) return 32'h17;
    return 32'hC0DE0000 | {18'b0, a};
  endfunction

  function automatic logic [31:0] word_at(input logic [13:0] a);
    return written[a] ? mem_arr[a] : base_word(a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (mem_en_o) begin
      if (mem_we_o) begin
        mem_arr[mem_addr_o] <= merge(word_at(mem_addr_o), mem_wdata_o, mem_be_o);
        written[mem_addr_o] <= 1'b1;
      end else begin
        mem_rdata <= word_at(mem_addr_o);
      end
    end
  end

  // ---------------- scoreboard ----------------
  int          n_pass  = 0;
  int          n_total = 0;
  logic [32:0] exp_q[$];          // {is_load, load_data}
  logic [31:0] exp_fetch;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Per-cycle trace of the SRAM side and completions.
  bit          tr_en  [0:4095];
  bit          tr_we  [0:4095];
  logic [3:0]  tr_be  [0:4095];
  logic [13:0] tr_addr[0:4095];
  logic [31:0] tr_wd  [0:4095];
  bit          tr_ld  [0:4095];
  bit          tr_st  [0:4095];
  bit          tr_iv  [0:4095];

  function automatic bit tr_fetch(input int c);
    return tr_en[c] && !tr_we[c] && (tr_addr[c] == 14'h40);
  endfunction

  // Monitor: sample away from the active edge.
  always @(negedge clk) begin
    logic [32:0] e;
    if (cyc < 4096) begin
      tr_en[cyc]   = mem_en_o;
      tr_we[cyc]   = mem_we_o;
      tr_be[cyc]   = mem_be_o;
      tr_addr[cyc] = mem_addr_o;
      tr_wd[cyc]   = mem_wdata_o;
      tr_ld[cyc]   = dm_load_done_o;
      tr_st[cyc]   = dm_store_done_o;
      tr_iv[cyc]   = im_valid_o;
    end
    if (dm_load_done_o || dm_store_done_o) begin
      if (dm_load_done_o && dm_store_done_o)
        chk("single_done_per_cycle", 32'd3, 32'd1);
      else if (exp_q.size() == 0)
        chk("spurious_done", {30'b0, dm_load_done_o, dm_store_done_o}, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("done_type", {30'b0, dm_load_done_o, dm_store_done_o}, e[32] ? 32'd2 : 32'd1);
        if (dm_load_done_o) chk("load_data", dm_data_l_o, e[31:0]);
      end
    end
    if (im_valid_o) chk("fetch_data", im_data_o, exp_fetch);
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; presents one strobe for this cycle.
  task automatic drive_req(input bit st, input bit ld, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] sel,
                           input bit exp_acc, input bit track, input logic [31:0] exp_load);
    dm_store  = st;
    dm_load   = ld;
    dm_addr   = addr;
    dm_data_s = data;
    dm_sel    = sel;
    @(negedge clk);
    chk("dm_ready", {31'b0, dm_ready_o}, {31'b0, exp_acc});
    if (exp_acc && track) exp_q.push_back({ld && !st, exp_load});
    next_cycle();
    dm_store = 1'b0;
    dm_load  = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s;
    int r;
    rst_n     = 1'b0;
    im_addr   = 32'h100;
    exp_fetch = 32'h13;
    dm_addr   = '0;
    dm_data_s = '0;
    dm_sel    = '0;
    dm_load   = 1'b0;
    dm_store  = 1'b0;

    // Reset held for three cycles.
    repeat (3) begin
      @(negedge clk);
      chk("rst_im_valid", {31'b0, im_valid_o}, 0);
      chk("rst_load_done", {31'b0, dm_load_done_o}, 0);
      chk("rst_store_done", {31'b0, dm_store_done_o}, 0);
      chk("rst_dm_ready", {31'b0, dm_ready_o}, 1);
      chk("rst_mem_en", {31'b0, mem_en_o}, 0);
      chk("rst_mem_we", {31'b0, mem_we_o}, 0);
      chk("rst_mem_be", {28'b0, mem_be_o}, 0);
      chk("rst_mem_addr", {18'b0, mem_addr_o}, 0);
      chk("rst_mem_wdata", mem_wdata_o, 0);
      chk("rst_im_data", im_data_o, 0);
      chk("rst_dm_data", dm_data_l_o, 0);
    end
    next_cycle();
    rst_n = 1'b1;
    r = cyc;
    @(negedge clk);
    chk("first_fetch_en", {31'b0, mem_en_o}, 1);
    chk("first_fetch_addr", {18'b0, mem_addr_o}, 32'h40);
    chk("first_fetch_no_valid", {31'b0, im_valid_o}, 0);
    @(negedge clk);
    chk("first_fetch_valid", {31'b0, im_valid_o}, 1);
    chk("first_fetch_word", im_data_o, 32'h13);
    repeat (3) next_cycle();
    for (int k = 1; k <= 3; k++) chk("idle_stream_valid", {31'b0, tr_iv[r+k]}, 1);

    // Single load of byte 0x40 (word 0x10).
    next_cycle();
    s = cyc;
    drive_req(1'b0, 1'b1, 32'h40, 32'h0, 4'h0, 1'b1, 1'b1, 32'hC0DE0010);
    repeat (4) next_cycle();
    chk("ld_access_addr", {18'b0, tr_addr[s+1]}, 32'h10);
    chk("ld_access_we", {31'b0, tr_we[s+1]}, 0);
    chk("ld_access_be", {28'b0, tr_be[s+1]}, 32'hF);
    chk("ld_not_early", {31'b0, tr_ld[s+1]}, 0);
    chk("ld_done_time", {31'b0, tr_ld[s+2]}, 1);
    chk("ld_no_iv_on_done", {31'b0, tr_iv[s+2]}, 0);

    // Store 0xDEADBEEF sel 0011 to 0x80, then load 0x80 next cycle.
    next_cycle();
    s = cyc;
    drive_req(1'b1, 1'b0, 32'h80, 32'hDEADBEEF, 4'b0011, 1'b1, 1'b1, 32'h0);
    drive_req(1'b0, 1'b1, 32'h80, 32'h0, 4'h0, 1'b1, 1'b1, 32'hC0DEBEEF);
    repeat (4) next_cycle();
    chk("st_access_we", {31'b0, tr_we[s+1]}, 1);
    chk("st_access_be", {28'b0, tr_be[s+1]}, 32'h3);
    chk("st_access_addr", {18'b0, tr_addr[s+1]}, 32'h20);
    chk("st_access_wdata", tr_wd[s+1], 32'hDEADBEEF);
    chk("st_then_ld_we", {31'b0, tr_we[s+2]}, 0);
    chk("st_then_ld_addr", {18'b0, tr_addr[s+2]}, 32'h20);
    chk("st_done_time", {31'b0, tr_st[s+2]}, 1);
    chk("st_then_ld_done_time", {31'b0, tr_ld[s+3]}, 1);

    // Load and store together count as a store.
    next_cycle();
    s = cyc;
    drive_req(1'b1, 1'b1, 32'h84, 32'hAA000000, 4'b1000, 1'b1, 1'b1, 32'h0);
    drive_req(1'b0, 1'b1, 32'h84, 32'h0, 4'h0, 1'b1, 1'b1, 32'hAADE0021);
    repeat (4) next_cycle();
    chk("both_strobe_we", {31'b0, tr_we[s+1]}, 1);
    chk("both_strobe_be", {28'b0, tr_be[s+1]}, 32'h8);
    chk("both_strobe_store_done", {31'b0, tr_st[s+2]}, 1);
    chk("both_strobe_no_load_done", {31'b0, tr_ld[s+2]}, 0);

    // Continuous load strobes for 20 cycles: FIFO fills, every 4th strobe from
    // t=5 is refused, grants run DM,DM,DM,FETCH.
    next_cycle();
    s = cyc;
    for (int t = 0; t < 20; t++) begin
      drive_req(1'b0, 1'b1, 32'h400 + 32'(4*t), 32'h0, 4'h0,
                !(t >= 5 && ((t - 5) % 4) == 0), 1'b1, 32'hC0DE0100 + 32'(t));
    end
    repeat (6) next_cycle();
    for (int t = 0; t <= 20; t++) begin
      chk("burst_grant_is_fetch", {31'b0, tr_fetch(s+t)}, {31'b0, (t % 4) == 0});
      chk("burst_im_valid", {31'b0, tr_iv[s+t+1]}, {31'b0, (t % 4) == 0});
    end

    // Fetch address change right after a fetch grant.
    next_cycle();
    s = cyc;
    im_addr   = 32'h104;
    exp_fetch = 32'h17;
    repeat (3) next_cycle();
    chk("addr_change_no_valid", {31'b0, tr_iv[s]}, 0);
    chk("addr_change_refetch", {18'b0, tr_addr[s]}, 32'h41);
    chk("addr_change_valid_next", {31'b0, tr_iv[s+1]}, 1);
    im_addr   = 32'h100;
    exp_fetch = 32'h13;
    repeat (3) next_cycle();

    // Reset while a load is queued: flushed, no done afterwards.
    s = cyc;
    drive_req(1'b0, 1'b1, 32'h800, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_mem_en", {31'b0, mem_en_o}, 0);
    chk("midrst_mem_addr", {18'b0, mem_addr_o}, 0);
    chk("midrst_dm_ready", {31'b0, dm_ready_o}, 1);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    repeat (3) next_cycle();
    for (int k = 1; k <= 4; k++) chk("midrst_no_load_done", {31'b0, tr_ld[s+k]}, 0);
    for (int k = 1; k <= 3; k++) chk("midrst_no_valid", {31'b0, tr_iv[s+k]}, 0);
    chk("midrst_first_is_fetch", {18'b0, tr_addr[s+3]}, 32'h40);
    chk("midrst_first_en", {31'b0, tr_en[s+3]}, 1);
    chk("midrst_fetch_valid", {31'b0, tr_iv[s+4]}, 1);

    repeat (2) next_cycle();
    chk("exp_q_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
